// File: rtl/bp_table_ctrl_pkg.sv
// Shared defaults, FSM state type and counter helper for bp_table_ctrl.
package bp_table_ctrl_pkg;

  localparam int         BP_XLEN        = 32;
  localparam int         BP_SIZE_WIDTH  = 4;
  localparam int         BP_UPD_Q_DEPTH = 4;
  localparam logic [1:0] BP_INIT_VAL    = 2'b01;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_UPD_RD = 2'd2,
    ST_UPD_WR = 2'd3
  } bp_state_e;

  // 2-bit saturating step toward the actual branch outcome.
  function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic jump);
    if (jump) return (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    return (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/bp_table_ctrl_fifo.sv
// Synchronous FIFO holding queued predictor updates; full/empty from registered occupancy.
module bp_update_fifo #(
  parameter int W     = 6,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bp_table_ctrl.sv
// Single-port 2-bit predictor SRAM sequencer: init sweep, fetch lookups, queued RMW updates.
// Optional statistics counters are built when BP_TABLE_CTRL_STATS_EN is defined.
module bp_table_ctrl
  import bp_table_ctrl_pkg::*;
#(
  parameter int         XLEN     = BP_XLEN,
  parameter int         IDX_W    = BP_SIZE_WIDTH,
  parameter int         Q_DEPTH  = BP_UPD_Q_DEPTH,
  parameter logic [1:0] INIT_VAL = BP_INIT_VAL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rdy,
  input  logic             flush,
  input  logic             fet_req,
  input  logic [XLEN-1:0]  fet_pc,
  output logic             fet_gnt,
  output logic             bp_pred_valid,
  output logic             bp_pred,
  input  logic             rob_bp_enable,
  input  logic [XLEN-1:0]  rob_bp_inst_addr,
  input  logic             rob_bp_jump,
  input  logic             rob_bp_correct,
  output logic             bp_full,
  output logic             bp_busy,
  output logic             tbl_en,
  output logic             tbl_we,
  output logic [IDX_W-1:0] tbl_addr,
  output logic [1:0]       tbl_wdata,
  input  logic [1:0]       tbl_rdata,
  output logic [XLEN-1:0]  bp_correct_cnt,
  output logic [XLEN-1:0]  bp_total_cnt
);

`ifdef BP_TABLE_CTRL_STATS_EN
  localparam int ENT_W = IDX_W + 2;
`else
  localparam int ENT_W = IDX_W + 1;
`endif

  bp_state_e        state;
  bp_state_e        state_nxt;
  logic [IDX_W-1:0] sweep_ptr;
  logic             reissue;
  logic [1:0]       rd_data;
  logic             fet_sel;
  logic             upd_sel;
  logic             q_push;
  logic             q_pop;
  logic             q_full;
  logic             q_empty;
  logic [ENT_W-1:0] q_wdata;
  logic [ENT_W-1:0] q_head;
  logic [IDX_W-1:0] head_idx;
  logic             head_jump;
  logic             unused_bits;

`ifdef BP_TABLE_CTRL_STATS_EN
  assign q_wdata = {rob_bp_inst_addr[IDX_W:1], rob_bp_jump, rob_bp_correct};
`else
  assign q_wdata = {rob_bp_inst_addr[IDX_W:1], rob_bp_jump};
`endif
  assign head_idx  = q_head[ENT_W-1 -: IDX_W];
  assign head_jump = q_head[ENT_W-IDX_W-1];
  assign q_push    = rob_bp_enable && !flush && rdy;
  assign q_pop     = (state == ST_UPD_WR) && rdy;

  bp_update_fifo #(.W(ENT_W), .DEPTH(Q_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (q_push),
    .pop   (q_pop),
    .wdata (q_wdata),
    .rdata (q_head),
    .full  (q_full),
    .empty (q_empty)
  );

  // A full queue steals the read slot from fetch so commits cannot stall forever.
  always_comb begin
    fet_sel = 1'b0;
    upd_sel = 1'b0;
    if (state == ST_IDLE && rdy) begin
      if (q_full)                fet_sel = 1'b0;
      else if (fet_req && !flush) fet_sel = 1'b1;
      if (q_full || (!q_empty && !(fet_req && !flush))) upd_sel = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   state <= ST_INIT;
    else if (rdy) state <= state_nxt;
  end

  // A read re-issued after a stall keeps the FSM in UPD_RD one extra cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:   if (sweep_ptr == '1) state_nxt = ST_IDLE;
      ST_IDLE:   if (upd_sel) state_nxt = ST_UPD_RD;
      ST_UPD_RD: if (!reissue) state_nxt = ST_UPD_WR;
      ST_UPD_WR: state_nxt = ST_IDLE;
      default:   state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    tbl_en    = 1'b0;
    tbl_we    = 1'b0;
    tbl_addr  = head_idx;
    tbl_wdata = 2'b00;
    case (state)
      ST_INIT: begin
        tbl_en    = rdy;
        tbl_we    = 1'b1;
        tbl_addr  = sweep_ptr;
        tbl_wdata = INIT_VAL;
      end
      ST_IDLE: begin
        tbl_en   = fet_sel || upd_sel;
        tbl_addr = fet_sel ? fet_pc[IDX_W:1] : head_idx;
      end
      ST_UPD_RD: tbl_en = rdy && reissue;
      ST_UPD_WR: begin
        tbl_en    = rdy;
        tbl_we    = 1'b1;
        tbl_wdata = sat_step(rd_data, head_jump);
      end
      default: tbl_en = 1'b0;
    endcase
  end

  assign fet_gnt = fet_sel;
  assign bp_busy = (state == ST_INIT);
  assign bp_full = q_full;
  assign bp_pred = bp_pred_valid && tbl_rdata[1];

  // The SRAM read result may be lost while rdy is low, so UPD_RD remembers to read again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_ptr     <= '0;
      reissue       <= 1'b0;
      rd_data       <= 2'b00;
      bp_pred_valid <= 1'b0;
    end else if (!rdy) begin
      if (state == ST_UPD_RD) reissue <= 1'b1;
    end else begin
      if (state == ST_INIT) sweep_ptr <= sweep_ptr + IDX_W'(1);
      if (state == ST_UPD_RD) begin
        reissue <= 1'b0;
        if (!reissue) rd_data <= tbl_rdata;
      end
      bp_pred_valid <= fet_sel;
    end
  end

`ifdef BP_TABLE_CTRL_STATS_EN
  logic [XLEN-1:0] total_q;
  logic [XLEN-1:0] correct_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q   <= '0;
      correct_q <= '0;
    end else if (q_pop) begin
      total_q   <= total_q + XLEN'(1);
      correct_q <= correct_q + XLEN'(q_head[0]);
    end
  end

  assign bp_total_cnt   = total_q;
  assign bp_correct_cnt = correct_q;
  assign unused_bits    = ^{fet_pc[XLEN-1:IDX_W+1], fet_pc[0],
                            rob_bp_inst_addr[XLEN-1:IDX_W+1], rob_bp_inst_addr[0]};
`else
  assign bp_total_cnt   = '0;
  assign bp_correct_cnt = '0;
  assign unused_bits    = ^{fet_pc[XLEN-1:IDX_W+1], fet_pc[0],
                            rob_bp_inst_addr[XLEN-1:IDX_W+1], rob_bp_inst_addr[0],
                            rob_bp_correct};
`endif

endmodule

// File: tb/tb_bp_table_ctrl.sv
// Scoreboard bench for bp_table_ctrl: random traffic against a table/queue reference model.
`timescale 1ns/1ps
module tb_bp_table_ctrl;

  localparam int XLEN  = 32;
  localparam int IDX_W = 4;
  localparam int N     = 16;
  localparam int QD    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             rdy = 1'b0;
  logic             flush = 1'b0;
  logic             fet_req = 1'b0;
  logic [XLEN-1:0]  fet_pc = '0;
  logic             rob_bp_enable = 1'b0;
  logic [XLEN-1:0]  rob_bp_inst_addr = '0;
  logic             rob_bp_jump = 1'b0;
  logic             rob_bp_correct = 1'b0;
  logic             fet_gnt, bp_pred_valid, bp_pred, bp_full, bp_busy, tbl_en, tbl_we;
  logic [IDX_W-1:0] tbl_addr;
  logic [1:0]       tbl_wdata;
  logic [1:0]       tbl_rdata;
  logic [XLEN-1:0]  bp_correct_cnt, bp_total_cnt;

  always #5 clk = ~clk;

  bp_table_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
    .fet_req(fet_req), .fet_pc(fet_pc), .fet_gnt(fet_gnt),
    .bp_pred_valid(bp_pred_valid), .bp_pred(bp_pred),
    .rob_bp_enable(rob_bp_enable), .rob_bp_inst_addr(rob_bp_inst_addr),
    .rob_bp_jump(rob_bp_jump), .rob_bp_correct(rob_bp_correct),
    .bp_full(bp_full), .bp_busy(bp_busy),
    .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
    .tbl_wdata(tbl_wdata), .tbl_rdata(tbl_rdata),
    .bp_correct_cnt(bp_correct_cnt), .bp_total_cnt(bp_total_cnt)
  );

  // Table macro model: output register holds its value when not reading.
  logic [1:0] mem [N];
  logic [1:0] sram_q = 2'b00;
  always @(posedge clk) begin
    if (tbl_en) begin
      if (tbl_we) mem[tbl_addr] <= tbl_wdata;
      else        sram_q <= mem[tbl_addr];
    end
  end
  assign tbl_rdata = sram_q;

  typedef struct {int idx; bit jump; bit correct;} upd_t;

  int     checks = 0;
  int     failures = 0;
  upd_t   ref_q[$];
  bit     pred_q[$];
  int     ref_tbl[N];
  int     sweep_cnt = 0;
  bit     prev_busy = 1'b1;
  longint exp_total = 0;
  longint exp_correct = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int satRef(input int v, input bit j);
    if (j) return (v < 3) ? v + 1 : 3;
    return (v > 0) ? v - 1 : 0;
  endfunction

  function automatic logic [XLEN-1:0] mkPc(input int idx);
    logic [XLEN-1:0] pc;
    pc = $urandom;
    pc[IDX_W:1] = idx[IDX_W-1:0];
    return pc;
  endfunction

  // Monitor: owns the reference table, the expected-update queue and the prediction queue.
  always @(negedge clk) begin : mon
    bit   model_full;
    upd_t e;
    int   v;
    if (!rst_n) begin
      ref_q.delete();
      pred_q.delete();
      sweep_cnt   = 0;
      prev_busy   = 1'b1;
      exp_total   = 0;
      exp_correct = 0;
    end else begin
`ifdef BP_TABLE_CTRL_STATS_EN
      checkOutput("stat_total", bp_total_cnt, exp_total);
      checkOutput("stat_correct", bp_correct_cnt, exp_correct);
`else
      checkOutput("stat_total", bp_total_cnt, 0);
      checkOutput("stat_correct", bp_correct_cnt, 0);
`endif
      if (!rdy) checkOutput("tbl_en_stalled", tbl_en, 0);
      model_full = (ref_q.size() == QD);
      checkOutput("bp_full", bp_full, model_full);

      if (bp_pred_valid && rdy) begin
        if (pred_q.size() == 0) checkOutput("unexpected_pred_valid", 1, 0);
        else checkOutput("bp_pred", bp_pred, pred_q.pop_front());
      end

      if (bp_busy && tbl_en) begin
        checkOutput("init_we", tbl_we, 1);
        checkOutput("init_addr", tbl_addr, sweep_cnt);
        checkOutput("init_data", tbl_wdata, 1);
        if (sweep_cnt < N) ref_tbl[sweep_cnt] = 1;
        sweep_cnt++;
      end
      if (prev_busy && !bp_busy) checkOutput("init_writes", sweep_cnt, N);
      prev_busy = bp_busy;

      if (!bp_busy && tbl_en && tbl_we) begin
        if (ref_q.size() == 0) checkOutput("unexpected_write", 1, 0);
        else begin
          e = ref_q.pop_front();
          v = satRef(ref_tbl[e.idx], e.jump);
          checkOutput("upd_addr", tbl_addr, e.idx);
          checkOutput("upd_data", tbl_wdata, v);
          ref_tbl[e.idx] = v;
          exp_total++;
          exp_correct += e.correct;
        end
      end

      if (fet_gnt) begin
        checkOutput("gnt_legal", fet_req && !flush && rdy && !bp_busy && !bp_full, 1);
        checkOutput("gnt_read", tbl_en && !tbl_we && (tbl_addr == fet_pc[IDX_W:1]), 1);
        pred_q.push_back(ref_tbl[fet_pc[IDX_W:1]] >= 2);
      end

      if (rob_bp_enable && !flush && rdy && !model_full) begin
        e.idx     = int'(rob_bp_inst_addr[IDX_W:1]);
        e.jump    = rob_bp_jump;
        e.correct = rob_bp_correct;
        ref_q.push_back(e);
      end
    end
  end

  task automatic applyStimulus(input bit r, input bit fl, input bit fq, input int fidx,
                               input bit en, input int uidx, input bit j, input bit c);
    @(posedge clk); #1;
    rdy = r; flush = fl; fet_req = fq; fet_pc = mkPc(fidx);
    rob_bp_enable = en; rob_bp_inst_addr = mkPc(uidx); rob_bp_jump = j; rob_bp_correct = c;
  endtask

  task automatic idle();
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    int n;
    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; fet_req = 1'b0; rob_bp_enable = 1'b0;
    #1;
    checkOutput("rst_busy", bp_busy, 1);
    checkOutput("rst_pred_valid", bp_pred_valid, 0);
    checkOutput("rst_pred", bp_pred, 0);
    checkOutput("rst_full", bp_full, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    @(negedge clk);
    while (bp_busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    checkOutput("init_cycles", n, N);
  endtask

  task automatic waitDrain();
    int n = 0;
    while (ref_q.size() != 0 && n < 200) begin
      idle();
      n++;
    end
    checkOutput("drain_done", ref_q.size(), 0);
    repeat (6) idle();
  endtask

  task automatic randomPhase(input int cycles, input int rdy_pct, input int fet_pct, input int push_pct);
    for (int i = 0; i < cycles; i++)
      applyStimulus(($urandom % 100) < rdy_pct, ($urandom % 100) < 4, ($urandom % 100) < fet_pct,
                    int'($urandom % N), ($urandom % 100) < push_pct, int'($urandom % N),
                    1'($urandom), 1'($urandom));
    waitDrain();
  endtask

  initial begin
    doReset();

    // First lookup after the sweep sees weakly not-taken.
    applyStimulus(1'b1, 1'b0, 1'b1, 4, 1'b0, 0, 1'b0, 1'b0);
    @(negedge clk) checkOutput("fetch_gnt", fet_gnt, 1);
    idle();
    @(negedge clk);
    checkOutput("fetch_valid", bp_pred_valid, 1);
    checkOutput("fetch_pred_init", bp_pred, 0);

    // Three taken updates on one entry saturate at strongly taken.
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b1, 4, 1'b1, 1'b1);
    waitDrain();
    applyStimulus(1'b1, 1'b0, 1'b1, 4, 1'b0, 0, 1'b0, 1'b0);
    idle();
    @(negedge clk) checkOutput("pred_after_sat", bp_pred, 1);
    repeat (2) idle();

    // Fetch starves the queue until it fills, then the update read wins.
    applyStimulus(1'b1, 1'b0, 1'b1, 2, 1'b1, 9, 1'b0, 1'b0);
    @(negedge clk) checkOutput("starve_gnt0", fet_gnt, 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 3, 1'b0, 0, 1'b0, 1'b0);
    @(negedge clk) checkOutput("starve_gnt1", fet_gnt, 1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, k, 1'b1, 10 + k, 1'b1, 1'b0);
      @(negedge clk) checkOutput("fill_gnt", fet_gnt, 1);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 5, 1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("full_flag", bp_full, 1);
    checkOutput("full_no_gnt", fet_gnt, 0);
    checkOutput("full_upd_read", tbl_en && !tbl_we, 1);
    waitDrain();

    // Flush: push ignored, queued updates still land, no prediction next cycle.
    applyStimulus(1'b1, 1'b0, 1'b1, 1, 1'b1, 6, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1, 1'b1, 8, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1, 1'b1, 12, 1'b1, 1'b1);
    @(negedge clk) checkOutput("flush_no_gnt", fet_gnt, 0);
    idle();
    @(negedge clk) checkOutput("flush_valid_low", bp_pred_valid, 0);
    waitDrain();

    // Stall in the middle of a read-modify-write.
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b1, 7, 1'b0, 1'b0);
    idle();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
      @(negedge clk) checkOutput("stall_tbl_en", tbl_en, 0);
    end
    waitDrain();
    applyStimulus(1'b1, 1'b0, 1'b1, 7, 1'b0, 0, 1'b0, 1'b0);
    idle();
    @(negedge clk) checkOutput("pred_after_stall", bp_pred, 0);
    repeat (2) idle();

    // Reset landing in the stalled read restarts the sweep from entry 0.
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b1, 3, 1'b1, 1'b0);
    idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    doReset();

    randomPhase(600, 100, 30, 30);
    randomPhase(600, 95, 80, 80);
    randomPhase(600, 75, 50, 50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
